// File: rtl/lane_sched_if.sv
// Requester/lane bundle for the lane scheduler.
// master drives requests and lane_ready; slave is the scheduler.
interface lane_sched_if #(
  parameter int NREQ = 4,
  parameter int DW   = 12,
  parameter int LENW = 3
);
  localparam int SW = $clog2(NREQ);

  logic [NREQ-1:0]           req;
  logic [NREQ-1:0][LENW-1:0] req_len;
  logic [NREQ-1:0][DW-1:0]   req_data;
  logic                      lane_ready;
  logic [NREQ-1:0]           gnt;
  logic [NREQ-1:0]           req_pop;
  logic                      lane_valid;
  logic [DW-1:0]             lane_data;
  logic [SW-1:0]             lane_src;
  logic                      abort;
  logic                      tmo_err;

  modport master (
    output req, req_len, req_data, lane_ready,
    input  gnt, req_pop, lane_valid, lane_data,
    input  lane_src, abort, tmo_err
  );

  modport slave (
    input  req, req_len, req_data, lane_ready,
    output gnt, req_pop, lane_valid, lane_data,
    output lane_src, abort, tmo_err
  );
endinterface

// File: rtl/lane_sched.sv
// Round-robin burst scheduler onto one lane,
// with drop/stall abort and sticky stall timeout.
module lane_sched #(
  parameter int NREQ = 4,
  parameter int DW   = 12,
  parameter int LENW = 3,
  parameter int TMO  = 15
) (
  input logic        clk,
  input logic        rst_n,
  lane_sched_if.slave bus
);
  localparam int SW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    GAP
  } state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   win_q, win_d;
  logic [SW-1:0]   last_q, last_d;
  logic [LENW:0]   beats_q, beats_d;
  logic [7:0]      stall_q, stall_d;
  logic            tmo_q, tmo_d;

  logic            found;
  logic [SW-1:0]   pick;
  int              idx;

  logic [NREQ-1:0] gnt;
  logic [NREQ-1:0] pop;
  logic            valid;
  logic [DW-1:0]   data;
  logic [SW-1:0]   src;
  logic            abrt;
  logic            tmo_hit;

  // first requester after last_winner, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        pick  = SW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    beats_d = beats_q;
    stall_d = stall_q;
    tmo_d   = tmo_q;
    gnt     = '0;
    pop     = '0;
    valid   = 1'b0;
    data    = '0;
    src     = '0;
    abrt    = 1'b0;
    tmo_hit = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          win_d   = pick;
          beats_d = {1'b0, bus.req_len[pick]} + 1'b1;
          stall_d = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        valid      = 1'b1;
        gnt[win_q] = 1'b1;
        data       = bus.req_data[win_q];
        src        = win_q;
        if (!bus.req[win_q]) begin
          abrt    = 1'b1;
          last_d  = win_q;
          beats_d = '0;
          stall_d = '0;
          state_d = GAP;
        end else if (bus.lane_ready) begin
          pop[win_q] = 1'b1;
          beats_d    = beats_q - 1'b1;
          stall_d    = '0;
          if (beats_q == (LENW+1)'(1)) begin
            last_d  = win_q;
            state_d = GAP;
          end
        end else begin
          stall_d = stall_q + 8'd1;
          if (stall_d == 8'(TMO)) begin
            abrt    = 1'b1;
            tmo_hit = 1'b1;
            tmo_d   = 1'b1;
            last_d  = win_q;
            beats_d = '0;
            stall_d = '0;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= '0;
      last_q  <= SW'(NREQ-1);
      beats_q <= '0;
      stall_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      beats_q <= beats_d;
      stall_q <= stall_d;
      tmo_q   <= tmo_d;
    end
  end

  // timeout is visible in the same cycle it fires
  assign bus.tmo_err    = tmo_q | tmo_hit;
  assign bus.gnt        = gnt;
  assign bus.req_pop    = pop;
  assign bus.lane_valid = valid;
  assign bus.lane_data  = data;
  assign bus.lane_src   = src;
  assign bus.abort      = abrt;
endmodule

// File: tb/tb_lane_sched.sv
// Directed bench for lane_sched with a
// scoreboard of expected pop/abort events.
module tb_lane_sched;
  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;
  int   pops_seen;

  typedef struct {
    logic        ab;
    int          src;
    logic [11:0] data;
  } ev_t;

  ev_t exp_q[$];

  lane_sched_if #(.NREQ(4), .DW(12), .LENW(3)) bus ();

  lane_sched #(
    .NREQ(4), .DW(12), .LENW(3), .TMO(15)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] dat(int i);
    return 12'(12'hA10 + i * 12'h111);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic push(logic ab, int src);
    ev_t e;
    e.ab   = ab;
    e.src  = src;
    e.data = dat(src);
    exp_q.push_back(e);
  endtask

  task automatic wait_gnt(string nm);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.gnt == 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_gnt_seen"}, 32'(bus.gnt != 0), 1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // monitor: invariants every cycle, scoreboard on pop/abort
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ($countones(bus.gnt) > 1 || $countones(bus.req_pop) > 1 ||
          (|bus.req_pop && !(bus.lane_valid && bus.lane_ready))) begin
        errors++;
        $display("FAIL invariant: gnt %0h pop %0h valid %0b ready %0b",
                 bus.gnt, bus.req_pop, bus.lane_valid, bus.lane_ready);
      end
      if (|bus.req_pop || bus.abort) begin
        ev_t e;
        if (|bus.req_pop) pops_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: pop %0h abort %0b",
                   bus.req_pop, bus.abort);
        end else begin
          logic [3:0] wpop;
          e = exp_q.pop_front();
          wpop = e.ab ? 4'b0 : 4'(1 << e.src);
          if (bus.abort !== e.ab || bus.req_pop !== wpop ||
              int'(bus.lane_src) != e.src || bus.lane_data !== e.data) begin
            errors++;
            $display("FAIL event: got abort %0b pop %0h src %0d data %0h want abort %0b pop %0h src %0d data %0h",
                     bus.abort, bus.req_pop, bus.lane_src, bus.lane_data,
                     e.ab, wpop, e.src, e.data);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int p0;
    cyc       = 0;
    checks    = 0;
    errors    = 0;
    pops_seen = 0;
    rst_n          = 1'b0;
    bus.req        = '0;
    bus.req_len    = '0;
    bus.lane_ready = 1'b1;
    for (int i = 0; i < 4; i++) bus.req_data[i] = dat(i);
    #3;
    chk("rst_gnt", 32'(bus.gnt), 0);
    chk("rst_valid", 32'(bus.lane_valid), 0);
    chk("rst_data", 32'(bus.lane_data), 0);
    chk("rst_src", 32'(bus.lane_src), 0);
    chk("rst_abort", 32'(bus.abort), 0);
    chk("rst_tmo", 32'(bus.tmo_err), 0);
    chk("rst_pop", 32'(bus.req_pop), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // all four requesting, 1-beat bursts
    step();
    for (int i = 0; i < 5; i++) push(1'b0, i % 4);
    bus.req = 4'b1111;
    t0 = 0;
    for (int i = 0; i < 5; i++) begin
      wait_gnt("rr");
      chk($sformatf("rr_order%0d", i), 32'(bus.gnt), 32'(1 << (i % 4)));
      if (i > 0) chk($sformatf("rr_spacing%0d", i), 32'(cyc - t0), 3);
      t0 = cyc;
    end
    step();
    bus.req = '0;
    repeat (2) step();

    // 4-beat burst; req_len change after grant ignored
    bus.req_len[2] = 3'd3;
    bus.req = 4'b0100;
    for (int i = 0; i < 4; i++) push(1'b0, 2);
    wait_gnt("b4");
    chk("b4_src", 32'(bus.lane_src), 2);
    step();
    bus.req_len[2] = 3'd0;
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("b4_pop%0d", i), 32'(bus.req_pop), 32'h4);
    end
    step();
    bus.req = '0;
    @(negedge clk);
    chk("b4_gap_valid", 32'(bus.lane_valid), 0);
    chk("b4_gap_data", 32'(bus.lane_data), 0);
    @(negedge clk);
    chk("b4_idle_gnt", 32'(bus.gnt), 0);
    step();

    // requester 1 drops after one beat
    bus.req_len[1] = 3'd3;
    bus.req = 4'b0010;
    push(1'b0, 1);
    push(1'b1, 1);
    wait_gnt("drop");
    chk("drop_gnt", 32'(bus.gnt), 32'h2);
    step();
    bus.req = 4'b0101;
    @(negedge clk);
    chk("drop_abort", 32'(bus.abort), 1);
    chk("drop_nopop", 32'(bus.req_pop), 0);
    push(1'b0, 2);
    wait_gnt("after_drop");
    chk("after_drop_gnt", 32'(bus.gnt), 32'h4);
    step();
    bus.req = '0;
    repeat (2) step();

    // 3 beats with lane_ready toggling
    bus.req_len[1] = 3'd2;
    bus.req = 4'b0010;
    for (int i = 0; i < 3; i++) push(1'b0, 1);
    p0 = pops_seen;
    wait_gnt("tog");
    step(); bus.lane_ready = 1'b0;
    step(); bus.lane_ready = 1'b1;
    step(); bus.lane_ready = 1'b0;
    step(); bus.lane_ready = 1'b1;
    step();
    bus.req = '0;
    chk("tog_pops", 32'(pops_seen - p0), 3);
    chk("tog_tmo", 32'(bus.tmo_err), 0);
    @(negedge clk);
    chk("tog_gap", 32'(bus.lane_valid), 0);
    step();

    // stall timeout
    bus.lane_ready = 1'b0;
    bus.req_len[3] = 3'd1;
    bus.req = 4'b1000;
    push(1'b1, 3);
    wait_gnt("tmo");
    chk("tmo_gnt", 32'(bus.gnt), 32'h8);
    for (int s = 2; s <= 15; s++) begin
      @(negedge clk);
      if (s == 14) begin
        chk("tmo_early_abort", 32'(bus.abort), 0);
        chk("tmo_early_err", 32'(bus.tmo_err), 0);
      end
      if (s == 15) begin
        chk("tmo_abort", 32'(bus.abort), 1);
        chk("tmo_err", 32'(bus.tmo_err), 1);
      end
    end
    step();
    bus.req = '0;
    bus.lane_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("tmo_sticky", 32'(bus.tmo_err), 1);
    step();

    // reset mid-burst, then 0 beats 3
    bus.req_len[3] = 3'd3;
    bus.req = 4'b1000;
    push(1'b0, 3);
    wait_gnt("mid");
    chk("mid_gnt", 32'(bus.gnt), 32'h8);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_gnt", 32'(bus.gnt), 0);
    chk("arst_valid", 32'(bus.lane_valid), 0);
    chk("arst_pop", 32'(bus.req_pop), 0);
    chk("arst_data", 32'(bus.lane_data), 0);
    chk("arst_src", 32'(bus.lane_src), 0);
    chk("arst_abort", 32'(bus.abort), 0);
    chk("arst_tmo", 32'(bus.tmo_err), 0);
    bus.req_len[0] = 3'd0;
    bus.req = 4'b1001;
    push(1'b0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_gnt("post_rst");
    chk("post_rst_gnt", 32'(bus.gnt), 32'h1);
    step();
    bus.req = '0;
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
